// File: rtl/rf_ctrl_pkg.sv
// Shared types and default sizing for the register-file write-port controller.
package rf_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_ctrl_state_t;

    // Requester index; also the encoding of the round-robin pointer.
    typedef logic req_id_t;

    function automatic req_id_t other_req(input req_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/rf_rr_arbiter2.sv
// Two-requester round-robin arbiter: combinational grant, registered priority pointer.
module rf_rr_arbiter2
    import rf_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant,
    output req_id_t    grant_idx
);

    req_id_t ptr;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        grant     = 2'b00;
        grant_idx = 1'b0;
        if (enable) begin
            unique case (valid)
                2'b01: begin
                    grant     = 2'b01;
                    grant_idx = 1'b0;
                end
                2'b10: begin
                    grant     = 2'b10;
                    grant_idx = 1'b1;
                end
                2'b11: begin
                    grant     = ptr ? 2'b10 : 2'b01;
                    grant_idx = ptr;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (|grant) begin
            ptr <= other_req(grant_idx);
        end
    end

endmodule

// File: rtl/rf_write_ctrl.sv
// Write-port controller for the 16x8 register file: round-robin arbitration of two
// requesters, plus an optional full-file clear sequencer enabled by RF_WRITE_CTRL_CLEAR_EN.
module rf_write_ctrl #(
    parameter int DATA_W = rf_ctrl_pkg::DATA_W,
    parameter int ADDR_W = rf_ctrl_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    output logic [1:0]        req_ready,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_w_address,
    output logic [DATA_W-1:0] rf_data
);

    import rf_ctrl_pkg::*;

    logic              arb_en;
    logic [1:0]        grant;
    req_id_t           grant_idx;
    logic              clr_wr;
    logic [ADDR_W-1:0] clr_addr;

`ifdef RF_WRITE_CTRL_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    rf_ctrl_state_t    state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_go;

    // clear_busy stays high one cycle past CLEAR so it covers the last write on the outputs;
    // that tail cycle also blocks the arbiter and ignores a new clear_start.
    assign clr_go   = (state == IDLE) && !clear_busy && clear_start;
    assign arb_en   = (state == IDLE) && !clear_busy && !clear_start;
    assign clr_wr   = (state == CLEAR);
    assign clr_addr = clr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    clear_done <= 1'b0;
                    clear_busy <= clr_go;
                    if (clr_go) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    clear_busy <= 1'b1;
                    clear_done <= (clr_cnt == LAST_ADDR);
                    clr_cnt    <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_ADDR) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic unused_clear_start;

    assign unused_clear_start = clear_start;
    assign arb_en     = 1'b1;
    assign clr_wr     = 1'b0;
    assign clr_addr   = '0;
    assign clear_busy = 1'b0;
    assign clear_done = 1'b0;
`endif

    rf_rr_arbiter2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (req_valid),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;

    // Address and data hold their last values on idle cycles; only the strobe drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write_en  <= 1'b0;
            rf_w_address <= '0;
            rf_data      <= '0;
        end else if (clr_wr) begin
            rf_write_en  <= 1'b1;
            rf_w_address <= clr_addr;
            rf_data      <= '0;
        end else if (|grant) begin
            rf_write_en  <= 1'b1;
            rf_w_address <= grant_idx ? req_addr1 : req_addr0;
            rf_data      <= grant_idx ? req_data1 : req_data0;
        end else begin
            rf_write_en  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Self-checking bench for rf_write_ctrl: timeline model of expected outputs plus a file model.
module tb_rf_write_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
`ifdef RF_WRITE_CTRL_CLEAR_EN
    localparam bit CLEAR_ON = 1'b1;
`else
    localparam bit CLEAR_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [1:0]    req_valid = 2'b00;
    logic [AW-1:0] req_addr0 = '0;
    logic [AW-1:0] req_addr1 = '0;
    logic [DW-1:0] req_data0 = '0;
    logic [DW-1:0] req_data1 = '0;
    logic [1:0]    req_ready;
    logic          clear_start = 1'b0;
    logic          clear_busy;
    logic          clear_done;
    logic          rf_write_en;
    logic [AW-1:0] rf_w_address;
    logic [DW-1:0] rf_data;

    rf_write_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_addr0    (req_addr0),
        .req_addr1    (req_addr1),
        .req_data0    (req_data0),
        .req_data1    (req_data1),
        .req_ready    (req_ready),
        .clear_start  (clear_start),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done),
        .rf_write_en  (rf_write_en),
        .rf_w_address (rf_w_address),
        .rf_data      (rf_data)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected output timeline. A clear is pre-scheduled as a list of future output states.
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          busy;
        logic          done;
    } step_t;

    step_t         clr_q[$];
    logic          m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    int            m_ptr = 0;
    logic [DW-1:0] exp_mem [DEPTH];
    logic [DW-1:0] rf_mem  [DEPTH];

    function automatic logic [1:0] model_ready(input logic [1:0] v, input int ptr, input bit blocked);
        if (blocked) return 2'b00;
        if (v == 2'b11) return (ptr == 0) ? 2'b01 : 2'b10;
        return v;
    endfunction

    function automatic bit model_blocked();
        return !rst_n || (clr_q.size() != 0) || (CLEAR_ON && clear_start);
    endfunction

    always @(negedge rst_n) begin
        m_we = 1'b0; m_addr = '0; m_data = '0; m_busy = 1'b0; m_done = 1'b0;
        m_ptr = 0;
        clr_q.delete();
    end

    always @(posedge clk) begin : model
        step_t      s;
        logic [1:0] r;
        if (rf_write_en) rf_mem[rf_w_address] <= rf_data;
        if (rst_n) begin
            if (m_we) exp_mem[m_addr] = m_data;
            if (clr_q.size() != 0) begin
                s = clr_q.pop_front();
                m_we = s.we; m_addr = s.addr; m_data = s.data; m_busy = s.busy; m_done = s.done;
            end else if (CLEAR_ON && clear_start) begin
                m_we = 1'b0; m_busy = 1'b1; m_done = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    s.we = 1'b1; s.addr = AW'(i); s.data = '0; s.busy = 1'b1; s.done = (i == DEPTH - 1);
                    clr_q.push_back(s);
                end
                s.we = 1'b0; s.addr = AW'(DEPTH - 1); s.data = '0; s.busy = 1'b0; s.done = 1'b0;
                clr_q.push_back(s);
            end else begin
                r = model_ready(req_valid, m_ptr, 1'b0);
                m_busy = 1'b0;
                m_done = 1'b0;
                if (r == 2'b01) begin
                    m_we = 1'b1; m_addr = req_addr0; m_data = req_data0; m_ptr = 1;
                end else if (r == 2'b10) begin
                    m_we = 1'b1; m_addr = req_addr1; m_data = req_data1; m_ptr = 0;
                end else begin
                    m_we = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("ready",    {30'd0, req_ready},    {30'd0, model_ready(req_valid, m_ptr, model_blocked())});
        check("write_en", {31'd0, rf_write_en},  {31'd0, m_we});
        check("address",  {28'd0, rf_w_address}, {28'd0, m_addr});
        check("data",     {24'd0, rf_data},      {24'd0, m_data});
        check("busy",     {31'd0, clear_busy},   {31'd0, m_busy});
        check("done",     {31'd0, clear_done},   {31'd0, m_done});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]    ctn_ready [4];
        logic [AW-1:0] ctn_addr  [4];
        bit            found;
        ctn_ready = '{2'b01, 2'b10, 2'b01, 2'b10};
        ctn_addr  = '{4'd1, 4'd2, 4'd1, 4'd2};
        for (int i = 0; i < DEPTH; i++) begin
            exp_mem[i] = '0;
            rf_mem[i]  = '0;
        end

        #2 rst_n = 1'b0;
        tick(); tick();
        @(negedge clk);
        check("rst_write_en", {31'd0, rf_write_en}, 32'd0);
        check("rst_ready",    {30'd0, req_ready},   32'd0);
        tick();
        rst_n = 1'b1;

        repeat (5) tick();
        @(negedge clk);
        check("idle_write_en", {31'd0, rf_write_en}, 32'd0);

        // Single requester 0
        tick();
        req_valid = 2'b01; req_addr0 = 4'd3; req_data0 = 8'hA5;
        @(negedge clk);
        check("single_ready", {30'd0, req_ready}, 32'h1);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        check("single_we",   {31'd0, rf_write_en},  32'h1);
        check("single_addr", {28'd0, rf_w_address}, 32'h3);
        check("single_data", {24'd0, rf_data},      32'hA5);
        tick();
        @(negedge clk);
        check("readback_3", {24'd0, rf_mem[3]}, 32'hA5);

        // Single requester 1 returns the pointer to requester 0
        tick();
        req_valid = 2'b10; req_addr1 = 4'd9; req_data1 = 8'h5A;
        tick();
        req_valid = 2'b00;
        tick();

        // Contention: grants alternate 0,1,0,1
        req_valid = 2'b11;
        req_addr0 = 4'd1; req_data0 = 8'h11;
        req_addr1 = 4'd2; req_data1 = 8'h22;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("contend_ready", {30'd0, req_ready}, {30'd0, ctn_ready[k]});
            if (k > 0) check("contend_addr", {28'd0, rf_w_address}, {28'd0, ctn_addr[k-1]});
            tick();
        end
        req_valid = 2'b00;
        @(negedge clk);
        check("contend_addr", {28'd0, rf_w_address}, {28'd0, ctn_addr[3]});
        tick();

        // Same-address race: later grant (requester 1) wins
        req_valid = 2'b11;
        req_addr0 = 4'd7; req_data0 = 8'h33;
        req_addr1 = 4'd7; req_data1 = 8'h44;
        tick(); tick();
        req_valid = 2'b00;
        tick(); tick();
        @(negedge clk);
        check("race_rb7",    {24'd0, rf_mem[7]},  32'h44);
        check("race_model7", {24'd0, exp_mem[7]}, 32'h44);

        // Reset mid-run aborts a pending write
        tick();
        req_valid = 2'b01; req_addr0 = 4'd4; req_data0 = 8'h66;
        tick();
        req_valid = 2'b00;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_we",   {31'd0, rf_write_en},  32'd0);
        check("midrst_addr", {28'd0, rf_w_address}, 32'd0);
        check("midrst_data", {24'd0, rf_data},      32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("midrst_rb4", {24'd0, rf_mem[4]}, 32'd0);
        tick();

`ifdef RF_WRITE_CTRL_CLEAR_EN
        // Fill with 0xFF, then clear; requests and a second clear_start are ignored meanwhile
        for (int a = 0; a < DEPTH; a++) begin
            req_valid = 2'b01; req_addr0 = AW'(a); req_data0 = 8'hFF;
            tick();
        end
        req_valid = 2'b00;
        tick();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 40 && !found; cyc++) begin
            req_valid   = (cyc < 8) ? 2'b01 : 2'b00;
            clear_start = (cyc == 4);
            if (rf_write_en && rf_w_address == 4'd15 && clear_done) found = 1'b1;
            else tick();
        end
        req_valid = 2'b00;
        clear_start = 1'b0;
        check("clear_done_seen", {31'd0, found},      32'h1);
        check("clear_busy_last", {31'd0, clear_busy}, 32'h1);
        tick(); tick();
        @(negedge clk);
        check("clear_busy_end", {31'd0, clear_busy}, 32'd0);
        for (int i = 0; i < DEPTH; i++) check("clear_rb", {24'd0, rf_mem[i]}, 32'd0);
        tick();

        // Reset at the sixth clear write leaves entries 5..15 untouched
        for (int a = 0; a < DEPTH; a++) begin
            req_valid = 2'b01; req_addr0 = AW'(a); req_data0 = 8'hFF;
            tick();
        end
        req_valid = 2'b00;
        tick();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 40 && !found; cyc++) begin
            if (rf_write_en && rf_w_address == 4'd5) found = 1'b1;
            else tick();
        end
        check("abort_point_seen", {31'd0, found}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, clear_busy},  32'd0);
        check("abort_we",   {31'd0, rf_write_en}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++)
            check("abort_rb", {24'd0, rf_mem[i]}, (i < 5) ? 32'd0 : 32'hFF);
`else
        // Clear feature absent: clear_start has no effect
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("noclr_busy", {31'd0, clear_busy},  32'd0);
            check("noclr_we",   {31'd0, rf_write_en}, 32'd0);
            tick();
        end
        check("noclr_rb7", {24'd0, rf_mem[7]}, 32'h44);
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
